// File: rtl/pe_cfg_pkg.sv
// Shared types and widths for the PE configuration path and its address generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_cfg_pkg;

    localparam int KDIM_W      = 4;   // kernel dimension / stride / padding field width
    localparam int IDIM_W      = 8;   // input feature-map dimension width
    localparam int PDIM_W      = 10;  // padded-coordinate width (H + 2P fits)
    localparam int ADDR_W_DFLT = 16;  // default feature-map address width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Convolution geometry captured at frame start
    typedef struct packed {
        logic [KDIM_W-1:0] kh;
        logic [KDIM_W-1:0] kw;
        logic [IDIM_W-1:0] h;
        logic [IDIM_W-1:0] w;
        logic [KDIM_W-1:0] s;
        logic [KDIM_W-1:0] p;
    } cfg_t;

endpackage

// File: rtl/pe_loop_cnt.sv
// One level of a nested loop: counts 0, step, 2*step ... while value <= limit, then wraps to 0.
// Latency: value updates the cycle after inc_en; value_nxt/wrap are combinational.
// Backpressure: none; it advances only when the caller asserts inc_en.
module pe_loop_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [CNT_W-1:0] step,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] value_nxt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    // One extra bit so value+step cannot alias back under the limit
    assign sum  = {1'b0, cnt_q} + {1'b0, step};
    assign wrap = (sum > {1'b0, limit});

    // Next count: clear dominates, otherwise step or wrap on increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_en) begin
            cnt_d = wrap ? '0 : sum[CNT_W-1:0];
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value     = cnt_q;
    assign value_nxt = cnt_d;

endmodule

// File: rtl/conv_addr_gen.sv
// Walks output positions and kernel taps, emitting one ifm/weight address beat per tap.
// Latency: start -> first beat 2 cycles; last accepted beat -> done 1 cycle. Optional perf counters: CONV_ADDR_GEN_PERF_EN.
// Backpressure: out_valid/out_ready; payload registered and held while stalled, counters advance only on accept.
module conv_addr_gen
    import pe_cfg_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int WADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         kernel_h,
    input  logic [3:0]         kernel_w,
    input  logic [7:0]         input_h,
    input  logic [7:0]         input_w,
    input  logic [3:0]         stride,
    input  logic [3:0]         padding,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  ifm_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               pad,
    output logic [7:0]         out_x,
    output logic [7:0]         out_y,
    output logic               win_last,
    output logic               last
`ifdef CONV_ADDR_GEN_PERF_EN
    ,
    output logic [31:0]        perf_run_cycles,
    output logic [31:0]        perf_stall_cycles
`endif
);

    localparam int LIN_W = PDIM_W + IDIM_W + 1;
    localparam int WLN_W = PDIM_W + KDIM_W + 1;

    state_e state_q, state_d;
    cfg_t   cfg_q, cfg_d, cfg_in, cfg_cur;
    logic   done_q, done_d, err_q, err_d;

    logic [ADDR_W-1:0]  ifm_q, ifm_d;
    logic [WADDR_W-1:0] wgt_q, wgt_d;
    logic               pad_q, pad_d;
    logic [7:0]         out_x_q, out_x_d, out_y_q, out_y_d;

    logic in_setup, in_run, accept, cfg_ok, load;

    logic [PDIM_W-1:0] kh_e, kw_e, h_e, w_e, s_e, p_e, hp, wp;
    logic [PDIM_W-1:0] oy_v, ox_v, ky_v, kx_v;
    logic [PDIM_W-1:0] oy_n, ox_n, ky_n, kx_n;
    logic              oy_wrap, ox_wrap, ky_wrap, kx_wrap;
    logic [PDIM_W-1:0] py, px, iy, ix;
    logic [LIN_W-1:0]  lin;
    logic [WLN_W-1:0]  wlin;
    logic              pad_n;

    assign cfg_in   = {kernel_h, kernel_w, input_h, input_w, stride, padding};
    assign in_setup = (state_q == ST_SETUP);
    assign in_run   = (state_q == ST_RUN);
    assign accept   = in_run && out_ready;

    // During SETUP the live inputs are the geometry; afterwards only the shadow copy is used
    assign cfg_cur = in_setup ? cfg_in : cfg_q;

    assign kh_e = PDIM_W'(cfg_cur.kh);
    assign kw_e = PDIM_W'(cfg_cur.kw);
    assign h_e  = PDIM_W'(cfg_cur.h);
    assign w_e  = PDIM_W'(cfg_cur.w);
    assign s_e  = PDIM_W'(cfg_cur.s);
    assign p_e  = PDIM_W'(cfg_cur.p);
    assign hp   = h_e + (p_e << 1);
    assign wp   = w_e + (p_e << 1);

    assign cfg_ok = (s_e != '0) && (kh_e != '0) && (kw_e != '0) && (kh_e <= hp) && (kw_e <= wp);

    // Loop nest, outermost first: oy origin, ox origin, ky, kx.
    // Origin limits are padded dim minus kernel, so "origin+K <= padded dim" needs no divider.
    pe_loop_cnt #(.CNT_W(PDIM_W)) u_kx (
        .clk(clk), .rst_n(rst_n), .clr(in_setup), .inc_en(accept),
        .step(PDIM_W'(1)), .limit(kw_e - PDIM_W'(1)),
        .value(kx_v), .value_nxt(kx_n), .wrap(kx_wrap)
    );
    pe_loop_cnt #(.CNT_W(PDIM_W)) u_ky (
        .clk(clk), .rst_n(rst_n), .clr(in_setup), .inc_en(accept && kx_wrap),
        .step(PDIM_W'(1)), .limit(kh_e - PDIM_W'(1)),
        .value(ky_v), .value_nxt(ky_n), .wrap(ky_wrap)
    );
    pe_loop_cnt #(.CNT_W(PDIM_W)) u_ox (
        .clk(clk), .rst_n(rst_n), .clr(in_setup), .inc_en(accept && kx_wrap && ky_wrap),
        .step(s_e), .limit(wp - kw_e),
        .value(ox_v), .value_nxt(ox_n), .wrap(ox_wrap)
    );
    pe_loop_cnt #(.CNT_W(PDIM_W)) u_oy (
        .clk(clk), .rst_n(rst_n), .clr(in_setup), .inc_en(accept && kx_wrap && ky_wrap && ox_wrap),
        .step(s_e), .limit(hp - kh_e),
        .value(oy_v), .value_nxt(oy_n), .wrap(oy_wrap)
    );

    // Payload of the beat that will be presented next, from the counters' next values
    always_comb begin
        py    = oy_n + ky_n;
        px    = ox_n + kx_n;
        pad_n = (py < p_e) || (py >= h_e + p_e) || (px < p_e) || (px >= w_e + p_e);
        iy    = py - p_e;
        ix    = px - p_e;
        lin   = LIN_W'(iy) * LIN_W'(w_e) + LIN_W'(ix);
        wlin  = WLN_W'(ky_n) * WLN_W'(kw_e) + WLN_W'(kx_n);
    end

    assign load = in_setup || accept;

    // Payload registers: loaded for the first beat in SETUP, then on each accepted beat
    always_comb begin
        ifm_d   = ifm_q;
        wgt_d   = wgt_q;
        pad_d   = pad_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        if (load) begin
            ifm_d = pad_n ? '0 : ADDR_W'(lin);
            wgt_d = WADDR_W'(wlin);
            pad_d = pad_n;
        end
        if (in_setup) begin
            out_x_d = '0;
            out_y_d = '0;
        end else if (accept && kx_wrap && ky_wrap) begin
            out_x_d = ox_wrap ? 8'd0 : out_x_q + 8'd1;
            if (ox_wrap) begin
                out_y_d = oy_wrap ? 8'd0 : out_y_q + 8'd1;
            end
        end
    end

    // Frame control: IDLE -> SETUP -> RUN/DONE, restart from DONE
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                cfg_d = cfg_in;
                if (cfg_ok) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept && last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, shadow config and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ifm_q   <= '0;
            wgt_q   <= '0;
            pad_q   <= 1'b0;
            out_x_q <= '0;
            out_y_q <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ifm_q   <= ifm_d;
            wgt_q   <= wgt_d;
            pad_q   <= pad_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign busy      = in_setup || in_run;
    assign out_valid = in_run;
    assign ifm_addr  = ifm_q;
    assign wgt_addr  = wgt_q;
    assign pad       = pad_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    // Flags come straight from the held counter state, so they are stable under stall
    assign win_last  = in_run && kx_wrap && ky_wrap;
    assign last      = win_last && ox_wrap && oy_wrap;

`ifdef CONV_ADDR_GEN_PERF_EN
    logic [31:0] run_cyc_q, run_cyc_d, stall_cyc_q, stall_cyc_d;

    // Saturating RUN / stall cycle counters, cleared at frame setup
    always_comb begin
        run_cyc_d   = run_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (in_setup) begin
            run_cyc_d   = '0;
            stall_cyc_d = '0;
        end else if (in_run) begin
            if (run_cyc_q != '1) run_cyc_d = run_cyc_q + 32'd1;
            if (!out_ready && stall_cyc_q != '1) stall_cyc_d = stall_cyc_q + 32'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cyc_q   <= '0;
            stall_cyc_q <= '0;
        end else begin
            run_cyc_q   <= run_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign perf_run_cycles   = run_cyc_q;
    assign perf_stall_cycles = stall_cyc_q;
`endif

endmodule
